// File: rtl/dsp_mul_rr_scheduler_if.sv
// Requester, multiplier and response signals of the shared Q15 multiplier scheduler.
// The slave modport is the scheduler's view. The master modport is the view of the
// surrounding logic: the requesters plus the multiplier that returns mul_q.
interface dsp_mul_rr_scheduler_if #(
    parameter int D_W  = 16,
    parameter int NREQ = 4
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // requester side
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*D_W-1:0] req_a;
    logic [NREQ*D_W-1:0] req_b;

    // multiplier side
    logic                mul_ce;
    logic [D_W-1:0]      mul_a;
    logic [D_W-1:0]      mul_b;
    logic [D_W-1:0]      mul_q;

    // response side
    logic [NREQ-1:0]     rsp_valid;
    logic [IDX_W-1:0]    rsp_idx;
    logic [D_W-1:0]      rsp_data;
    logic                busy;

    modport master (
        output req_valid, req_a, req_b, mul_q,
        input  req_ready, mul_ce, mul_a, mul_b, rsp_valid, rsp_idx, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_q,
        output req_ready, mul_ce, mul_a, mul_b, rsp_valid, rsp_idx, rsp_data, busy
    );
endinterface

// File: rtl/dsp_mul_rr_scheduler.sv
// Round-robin scheduler for one pipelined 16x16 signed Q15 multiplier.
// Each cycle one requester is granted. Its operands go straight to the multiplier.
// A tag {idx, sat} travels alongside the multiplier pipe, so every product returns
// to its requester in issue order. The only Q15 overflow case is -1 * -1; it is
// patched to 7FFFh on the way out.
module dsp_mul_rr_scheduler #(
    parameter int D_W     = 16,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  en,
    dsp_mul_rr_scheduler_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [D_W-1:0]   Q_MIN    = {1'b1, {(D_W-1){1'b0}}};
    localparam logic [D_W-1:0]   Q_MAX    = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             sat;
    } tag_t;

    logic                     run;
    logic [IDX_W-1:0]         rr_ptr;
    logic                     gnt_vld;
    logic [IDX_W-1:0]         gnt_idx;
    logic [NREQ-1:0][D_W-1:0] a_vec;
    logic [NREQ-1:0][D_W-1:0] b_vec;
    logic [D_W-1:0]           gnt_a;
    logic [D_W-1:0]           gnt_b;
    logic                     gnt_sat;
    logic [MUL_LAT-1:0]       vld_pipe;
    tag_t [MUL_LAT-1:0]       tag_pipe;
    logic [NREQ-1:0]          rsp_vld_q;
    logic [IDX_W-1:0]         rsp_idx_q;
    logic [D_W-1:0]           rsp_data_q;

    // The reset term keeps grants and operands at zero while rst_n is low,
    // even if requesters still hold valid.
    assign run   = en & rst_n;
    assign a_vec = bus.req_a;
    assign b_vec = bus.req_b;

    // Round-robin search starting at rr_ptr. The first valid requester wins.
    always_comb begin
        int               c;
        logic [IDX_W-1:0] cidx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = 0;
        cidx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            cidx = IDX_W'(c);
            if (!gnt_vld && bus.req_valid[cidx]) begin
                gnt_vld = 1'b1;
                gnt_idx = cidx;
            end
        end
        if (!run) gnt_vld = 1'b0;
    end

    // One-hot ready, one bit per requester. A bit rises only together with its valid.
    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign bus.req_ready[g] = gnt_vld && (gnt_idx == IDX_W'(g));
    end

    // The granted operands feed the multiplier's input registers directly.
    assign gnt_a      = gnt_vld ? a_vec[gnt_idx] : '0;
    assign gnt_b      = gnt_vld ? b_vec[gnt_idx] : '0;
    assign gnt_sat    = (gnt_a == Q_MIN) && (gnt_b == Q_MIN);
    assign bus.mul_a  = gnt_a;
    assign bus.mul_b  = gnt_b;
    assign bus.mul_ce = run;

    // After a grant, the pointer moves to the requester just past the winner.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (en && gnt_vld) begin
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    // The tag pipe mirrors the multiplier pipe stage for stage. It freezes with en,
    // which also freezes the multiplier through mul_ce.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (en) begin
            vld_pipe[0] <= gnt_vld;
            tag_pipe[0] <= '{idx: gnt_idx, sat: gnt_sat};
            for (int s = 1; s < MUL_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    // The response register captures the product when the last tag stage is valid.
    // The strobe lasts one cycle. The index and data hold until the next result.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= '0;
            rsp_idx_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= '0;
            if (en && vld_pipe[MUL_LAT-1]) begin
                rsp_vld_q[tag_pipe[MUL_LAT-1].idx] <= 1'b1;
                rsp_idx_q  <= tag_pipe[MUL_LAT-1].idx;
                rsp_data_q <= tag_pipe[MUL_LAT-1].sat ? Q_MAX : bus.mul_q;
            end
        end
    end

    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = |vld_pipe;
endmodule
